// File: rtl/lector_display_pkg.sv
// Shared constants for the multiplexed 7-segment display reader: segment patterns
// (bit6=a .. bit0=g), capture codes and the one-hot anode check.
package lector_display_pkg;

   localparam logic [6:0] SEG_0      = 7'b1111110;
   localparam logic [6:0] SEG_1      = 7'b0110000;
   localparam logic [6:0] SEG_2      = 7'b1101101;
   localparam logic [6:0] SEG_3      = 7'b1111001;
   localparam logic [6:0] SEG_4      = 7'b0110011;
   localparam logic [6:0] SEG_5      = 7'b1011011;
   localparam logic [6:0] SEG_6      = 7'b1011111;
   localparam logic [6:0] SEG_7      = 7'b1110000;
   localparam logic [6:0] SEG_8      = 7'b1111111;
   localparam logic [6:0] SEG_9      = 7'b1111011;
   localparam logic [6:0] SEG_BLANCO = 7'b0000000;

   localparam logic [3:0] COD_BLANCO   = 4'hF;
   localparam logic [3:0] COD_INVALIDO = 4'hE;

   // Anode vectors narrower than 8 bits are zero-extended by the caller.
   function automatic logic onehot_ok(input logic [7:0] v);
      return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
   endfunction

endpackage

// File: rtl/segmentos_a_bcd.sv
// Combinational 7-segment pattern decoder: digit patterns map to 0..9, blank to 4'hF,
// anything else to 4'hE with o_legal low.
module segmentos_a_bcd
   import lector_display_pkg::*;
(
   input  logic [6:0] i_segmento,
   output logic [3:0] o_codigo,
   output logic       o_legal
);

   always_comb begin
      o_codigo = COD_INVALIDO;
      o_legal  = 1'b1;
      case (i_segmento)
         SEG_0:      o_codigo = 4'h0;
         SEG_1:      o_codigo = 4'h1;
         SEG_2:      o_codigo = 4'h2;
         SEG_3:      o_codigo = 4'h3;
         SEG_4:      o_codigo = 4'h4;
         SEG_5:      o_codigo = 4'h5;
         SEG_6:      o_codigo = 4'h6;
         SEG_7:      o_codigo = 4'h7;
         SEG_8:      o_codigo = 4'h8;
         SEG_9:      o_codigo = 4'h9;
         SEG_BLANCO: o_codigo = COD_BLANCO;
         default:    o_legal  = 1'b0;
      endcase
   end

endmodule

// File: rtl/lector_display_multiplexado.sv
// Samples a multiplexed 7-segment bus, waits for each anode/pattern pair to be stable,
// and publishes a full frame of BCD codes. Optional decimal point: define PUNTO_DECIMAL_EN.
module lector_display_multiplexado
   import lector_display_pkg::*;
#(
   parameter int N_DIGITOS       = 4,
   parameter int ESTABLE_CICLOS  = 3,
   parameter bit SEG_ACTIVO_BAJO = 1'b0
)
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_DIGITOS-1:0]     anodo,
   input  logic [6:0]               segmento,
   output logic [4*N_DIGITOS-1:0]   digitos,
   output logic                     digitos_valido,
   output logic                     error_patron,
   output logic                     error_anodo
`ifdef PUNTO_DECIMAL_EN
   ,
   input  logic                     segmento_dp,
   output logic [N_DIGITOS-1:0]     puntos
`endif
);

   localparam int CNT_W = $clog2(ESTABLE_CICLOS + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ESTABLE_CICLOS);
`ifdef PUNTO_DECIMAL_EN
   localparam int MUESTRA_W = N_DIGITOS + 8;
`else
   localparam int MUESTRA_W = N_DIGITOS + 7;
`endif

   logic [N_DIGITOS-1:0]   w_anodo;
   logic [6:0]             w_seg;
   logic [MUESTRA_W-1:0]   w_muestra;
   logic [3:0]             w_codigo;
   logic                   w_legal;
   logic                   w_onehot;
   logic                   w_multi;
   logic                   w_igual;
   logic [CNT_W-1:0]       w_cnt_next;
   logic                   w_alcanza;
   logic                   w_captura;
   logic [N_DIGITOS-1:0]   w_mascara_nueva;
   logic                   w_fin;
   logic [4*N_DIGITOS-1:0] w_slots_next;

   logic [MUESTRA_W-1:0]   r_muestra;
   logic [CNT_W-1:0]       r_cnt;
   logic [N_DIGITOS-1:0]   r_mascara;
   logic [4*N_DIGITOS-1:0] r_slots;
   logic [4*N_DIGITOS-1:0] r_digitos;
   logic                   r_valido;
   logic                   r_err_patron;
   logic                   r_err_anodo;

   assign w_anodo = SEG_ACTIVO_BAJO ? ~anodo : anodo;
   assign w_seg   = SEG_ACTIVO_BAJO ? ~segmento : segmento;

`ifdef PUNTO_DECIMAL_EN
   logic                 w_dp;
   logic [N_DIGITOS-1:0] w_puntos_next;
   logic [N_DIGITOS-1:0] r_puntos_buf;
   logic [N_DIGITOS-1:0] r_puntos;

   assign w_dp      = SEG_ACTIVO_BAJO ? ~segmento_dp : segmento_dp;
   assign w_muestra = {w_anodo, w_seg, w_dp};
`else
   assign w_muestra = {w_anodo, w_seg};
`endif

   segmentos_a_bcd u_decod (
      .i_segmento (w_seg),
      .o_codigo   (w_codigo),
      .o_legal    (w_legal)
   );

   assign w_onehot = onehot_ok(8'(w_anodo));
   assign w_multi  = (w_anodo != '0) && !w_onehot;
   assign w_igual  = (w_muestra == r_muestra);

   // Gaps and multi-anode samples reset the count; a saturated count never re-triggers.
   always_comb begin
      w_cnt_next = r_cnt;
      if (!w_onehot)
         w_cnt_next = '0;
      else if (!w_igual)
         w_cnt_next = CNT_W'(1);
      else if (r_cnt != CNT_MAX)
         w_cnt_next = r_cnt + CNT_W'(1);
      w_alcanza = w_onehot && (w_cnt_next == CNT_MAX) && !(w_igual && (r_cnt == CNT_MAX));
   end

   assign w_captura       = w_alcanza && ((r_mascara & w_anodo) == '0);
   assign w_mascara_nueva = w_captura ? (r_mascara | w_anodo) : r_mascara;
   assign w_fin           = w_captura && (w_mascara_nueva == '1);

   always_comb begin
      w_slots_next = r_slots;
      for (int i = 0; i < N_DIGITOS; i++)
         if (w_captura && w_anodo[i])
            w_slots_next[4*i +: 4] = w_codigo;
   end

`ifdef PUNTO_DECIMAL_EN
   always_comb begin
      w_puntos_next = r_puntos_buf;
      for (int i = 0; i < N_DIGITOS; i++)
         if (w_captura && w_anodo[i])
            w_puntos_next[i] = w_dp;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_puntos_buf <= '0;
         r_puntos     <= '0;
      end else begin
         r_puntos_buf <= w_puntos_next;
         if (w_fin)
            r_puntos <= w_puntos_next;
      end
   end

   assign puntos = r_puntos;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_muestra    <= '0;
         r_cnt        <= '0;
         r_mascara    <= '0;
         r_slots      <= '1;
         r_digitos    <= '1;
         r_valido     <= 1'b0;
         r_err_patron <= 1'b0;
         r_err_anodo  <= 1'b0;
      end else begin
         r_muestra    <= w_muestra;
         r_cnt        <= w_cnt_next;
         r_slots      <= w_slots_next;
         r_mascara    <= w_fin ? '0 : w_mascara_nueva;
         r_valido     <= w_fin;
         r_err_patron <= w_captura && !w_legal;
         r_err_anodo  <= w_multi;
         if (w_fin)
            r_digitos <= w_slots_next;
      end
   end

   assign digitos        = r_digitos;
   assign digitos_valido = r_valido;
   assign error_patron   = r_err_patron;
   assign error_anodo    = r_err_anodo;

endmodule

// File: tb/tb_lector_display_multiplexado.sv
// Scoreboard bench for the display reader: an active-high and an active-low instance.
module tb_lector_display_multiplexado;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  anodo, anodo_n;
   logic [6:0]  segmento, segmento_n;
   logic [15:0] digitos, digitos_n;
   logic        valido, valido_n, ep, ep_n, ea, ea_n;

   int n_chk = 0, n_fail = 0;
   int n_fr = 0, n_fr_n = 0, n_ep = 0, n_ep_n = 0, n_ea = 0, n_ea_n = 0;
   logic [15:0] q_hi[$];
   logic [15:0] q_lo[$];

   always #5 clk = ~clk;

   lector_display_multiplexado #(.N_DIGITOS(4), .ESTABLE_CICLOS(3), .SEG_ACTIVO_BAJO(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .anodo(anodo), .segmento(segmento),
      .digitos(digitos), .digitos_valido(valido), .error_patron(ep), .error_anodo(ea));

   lector_display_multiplexado #(.N_DIGITOS(4), .ESTABLE_CICLOS(3), .SEG_ACTIVO_BAJO(1'b1)) dut_n (
      .clk(clk), .rst_n(rst_n), .anodo(anodo_n), .segmento(segmento_n),
      .digitos(digitos_n), .digitos_valido(valido_n), .error_patron(ep_n), .error_anodo(ea_n));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] pat(input int d);
      case (d)
         0: return 7'b1111110;
         1: return 7'b0110000;
         2: return 7'b1101101;
         3: return 7'b1111001;
         4: return 7'b0110011;
         5: return 7'b1011011;
         6: return 7'b1011111;
         7: return 7'b1110000;
         8: return 7'b1111111;
         default: return 7'b1111011;
      endcase
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic hi(input int pos, input logic [6:0] p, input int n);
      anodo    = 4'(1 << pos);
      segmento = p;
      tick(n);
   endtask

   task automatic gap(input int n);
      anodo    = 4'h0;
      segmento = 7'h00;
      tick(n);
   endtask

   task automatic lo(input int pos, input logic [6:0] p, input int n);
      anodo_n    = ~4'(1 << pos);
      segmento_n = ~p;
      tick(n);
      anodo_n    = 4'hF;
      segmento_n = 7'h7F;
      tick(2);
   endtask

   // Output monitor: pops the scoreboard on every valid pulse and counts error pulses.
   initial forever begin
      @(negedge clk);
      if (valido) begin
         n_fr++;
         chk("frame_hi_queued", 32'(q_hi.size() != 0), 32'd1);
         if (q_hi.size() != 0) chk("digitos_hi", 32'(digitos), 32'(q_hi.pop_front()));
      end
      if (valido_n) begin
         n_fr_n++;
         chk("frame_lo_queued", 32'(q_lo.size() != 0), 32'd1);
         if (q_lo.size() != 0) chk("digitos_lo", 32'(digitos_n), 32'(q_lo.pop_front()));
      end
      if (ep)   n_ep++;
      if (ea)   n_ea++;
      if (ep_n) n_ep_n++;
      if (ea_n) n_ea_n++;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, got %0d frames expected 6", n_fr);
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; anodo = 4'h0; segmento = 7'h00; anodo_n = 4'hF; segmento_n = 7'h7F;
      tick(3);
      rst_n = 1'b1;
      chk("rst_digitos",   32'(digitos), 32'hFFFF);
      chk("rst_valido",    32'(valido), 32'd0);
      chk("rst_err",       32'({ep, ea}), 32'd0);
      chk("rst_digitos_n", 32'(digitos_n), 32'hFFFF);

      // 1: plain scan
      q_hi.push_back(16'h1359);
      hi(0, pat(9), 4); hi(1, pat(5), 4); hi(2, pat(3), 4); hi(3, pat(1), 4);
      gap(2);
      chk("t1_frames", 32'(n_fr), 32'd1);
      chk("t1_errs",   32'(n_ep + n_ea), 32'd0);
      chk("t1_hold",   32'(digitos), 32'h1359);

      // 2: two stable samples do not capture, three do
      q_hi.push_back(16'h6427);
      hi(0, pat(3), 2); hi(0, pat(7), 3); gap(1);
      hi(1, pat(2), 3); hi(2, pat(4), 3); hi(3, pat(6), 3);
      gap(2);
      q_hi.push_back(16'h5083);
      hi(0, pat(3), 3); hi(1, pat(8), 3); hi(2, pat(0), 3); hi(3, pat(5), 3);
      gap(2);
      chk("t2_frames", 32'(n_fr), 32'd3);

      // 3: illegal pattern on position 2
      q_hi.push_back(16'h2E61);
      hi(0, pat(1), 3); hi(1, pat(6), 3); hi(2, 7'b1000001, 3); hi(3, pat(2), 3);
      gap(2);
      chk("t3_frames",  32'(n_fr), 32'd4);
      chk("t3_err_pat", 32'(n_ep), 32'd1);
      chk("t3_err_an",  32'(n_ea), 32'd0);

      // 4: two anodes active mid-frame
      q_hi.push_back(16'h9876);
      hi(0, pat(6), 3); hi(1, pat(7), 3);
      anodo = 4'b0110; segmento = pat(4); tick(5);
      hi(2, pat(8), 3); hi(3, pat(9), 3);
      gap(2);
      chk("t4_err_an", 32'(n_ea), 32'd5);
      chk("t4_frames", 32'(n_fr), 32'd5);

      // 5: reset discards a partial frame
      hi(0, pat(4), 3); hi(1, pat(4), 3);
      anodo = 4'h0; segmento = 7'h00; rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      chk("t5_rst_digitos", 32'(digitos), 32'hFFFF);
      chk("t5_rst_valido",  32'(valido), 32'd0);
      hi(2, pat(1), 3); hi(3, pat(2), 3);
      gap(2);
      chk("t5_no_frame", 32'(n_fr), 32'd5);
      q_hi.push_back(16'h2143);
      hi(0, pat(3), 3); hi(1, pat(4), 3);
      gap(2);
      chk("t5_frames", 32'(n_fr), 32'd6);

      // 6: active-low bus with blanking gaps
      q_lo.push_back(16'h8000);
      lo(0, pat(0), 4); lo(1, pat(0), 4); lo(2, pat(0), 4); lo(3, pat(8), 4);
      chk("t6_frames", 32'(n_fr_n), 32'd1);
      chk("t6_errs",   32'(n_ep_n + n_ea_n), 32'd0);
      chk("t6_hold",   32'(digitos_n), 32'h8000);

      chk("q_hi_empty", 32'(q_hi.size()), 32'd0);
      chk("q_lo_empty", 32'(q_lo.size()), 32'd0);
      chk("final_err_pat", 32'(n_ep), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
